// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
//   Shared types for the memory arbiter slice: the 32-bit word type, the
//   arbiter FSM states and the RAM status encoding reported by the RAM.
//   No ports.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISERV = 2'd1,
    DSERV = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if
//   Bundles the cache-side request/hit signals and the RAM-side port seen by
//   memory_arbiter.
//   slave  : the arbiter (takes requests and RAM status, drives hits and RAM strobes)
//   master : the environment (datapath/cache requesters plus the RAM model)
//   Signals: iREN/iaddr -> ihit/iload, dREN/dWEN/daddr/dstore -> dhit/dload,
//            ramREN/ramWEN/ramaddr/ramstore -> ramload/ramstate, err_cnt.
interface memory_arbiter_if;
  import cpu_types_pkg::*;

  logic       iREN;
  word_t      iaddr;
  logic       ihit;
  word_t      iload;

  logic       dREN;
  logic       dWEN;
  word_t      daddr;
  word_t      dstore;
  logic       dhit;
  word_t      dload;

  logic       ramREN;
  logic       ramWEN;
  word_t      ramaddr;
  word_t      ramstore;
  word_t      ramload;
  ramstate_t  ramstate;

  logic [7:0] err_cnt;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, err_cnt
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, err_cnt
  );

endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Shares the single-ported system RAM between instruction fetch and data
//   access. One requester is granted per transaction; its command is latched
//   and held on the RAM port until the RAM reports ACCESS (one-cycle hit) or
//   ERROR (no hit, error counted, request re-arbitrated). Data has priority,
//   but after MAX_DSTREAK data completions with a fetch waiting, the fetch
//   is granted.
//   Ports:
//     CLK   - clock, rising edge
//     nRST  - synchronous active-low reset
//     mif   - memory_arbiter_if.slave (request/hit pairs, RAM port, err_cnt)
//
// state | meaning
// IDLE  | no transaction; arbitrate between pending requests
// ISERV | instruction fetch owns the RAM, waiting for ACCESS/ERROR
// DSERV | data access owns the RAM, waiting for ACCESS/ERROR
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int MAX_DSTREAK = 4
) (
  input logic             CLK,
  input logic             nRST,
  memory_arbiter_if.slave mif
);

  localparam logic [3:0] DSTREAK_MAX = 4'(MAX_DSTREAK);

  arb_state_t state;
  arb_state_t next_state;

  word_t      cmd_addr;
  word_t      cmd_store;
  logic       cmd_wen;
  logic [3:0] dstreak;
  logic [7:0] err_cnt;

  logic       dreq;
  logic       grant_i;
  logic       grant_d;
  logic       done_access;
  logic       done_error;

  always_comb begin
    dreq         = mif.dREN | mif.dWEN;
    next_state   = state;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    done_access  = 1'b0;
    done_error   = 1'b0;
    mif.ramREN   = 1'b0;
    mif.ramWEN   = 1'b0;
    mif.ihit     = 1'b0;
    mif.dhit     = 1'b0;
    mif.iload    = '0;
    mif.dload    = '0;
    // RAM address/data always show the latched command so they hold in IDLE.
    mif.ramaddr  = cmd_addr;
    mif.ramstore = cmd_store;
    mif.err_cnt  = err_cnt;

    case (state)
      IDLE: begin
        // A waiting fetch wins only once the data streak has hit its limit.
        if (dreq && !(mif.iREN && (dstreak == DSTREAK_MAX))) begin
          next_state = DSERV;
          grant_d    = 1'b1;
        end else if (mif.iREN) begin
          next_state = ISERV;
          grant_i    = 1'b1;
        end
      end

      ISERV: begin
        mif.ramREN = 1'b1;
        if (mif.ramstate == ACCESS) begin
          // A fetch that withdrew mid-transaction gets no hit.
          mif.ihit    = mif.iREN;
          mif.iload   = mif.ramload;
          done_access = 1'b1;
          next_state  = IDLE;
        end else if (mif.ramstate == ERROR) begin
          done_error = 1'b1;
          next_state = IDLE;
        end
      end

      DSERV: begin
        mif.ramWEN = cmd_wen;
        mif.ramREN = ~cmd_wen;
        if (mif.ramstate == ACCESS) begin
          mif.dhit    = dreq;
          mif.dload   = mif.ramload;
          done_access = 1'b1;
          next_state  = IDLE;
        end else if (mif.ramstate == ERROR) begin
          done_error = 1'b1;
          next_state = IDLE;
        end
      end

      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= IDLE;
      cmd_addr  <= '0;
      cmd_store <= '0;
      cmd_wen   <= 1'b0;
      dstreak   <= '0;
      err_cnt   <= '0;
    end else begin
      state <= next_state;

      if (grant_i || grant_d) begin
        cmd_addr  <= grant_d ? mif.daddr : mif.iaddr;
        cmd_wen   <= mif.dWEN;
        cmd_store <= mif.dstore;
      end

      // The streak only means something while a fetch is actually waiting.
      if (!mif.iREN) begin
        dstreak <= '0;
      end else if (done_access && (state == ISERV)) begin
        dstreak <= '0;
      end else if (done_access && (state == DSERV) && (dstreak != DSTREAK_MAX)) begin
        dstreak <= dstreak + 4'd1;
      end

      if (done_error && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter
//   Directed scenarios for memory_arbiter followed by a long randomized run
//   compared cycle by cycle against a transaction-level reference model.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int MAXD = 4;

  logic CLK;
  logic nRST;
  int   vectors;
  int   miscompares;
  int   exp_err;

  memory_arbiter_if mif ();

  memory_arbiter #(.MAX_DSTREAK(MAXD)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .mif  (mif)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    mif.iREN     = 1'b0;
    mif.iaddr    = '0;
    mif.dREN     = 1'b0;
    mif.dWEN     = 1'b0;
    mif.daddr    = '0;
    mif.dstore   = '0;
    mif.ramload  = '0;
    mif.ramstate = FREE;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    clear_inputs();
    step();
    step();
    @(negedge CLK);
    vectors++; if (mif.ramREN !== 1'b0) begin miscompares++; $display("FAIL rst_ramREN got %b want 0", mif.ramREN); end
    vectors++; if (mif.ramWEN !== 1'b0) begin miscompares++; $display("FAIL rst_ramWEN got %b want 0", mif.ramWEN); end
    vectors++; if ({mif.ihit, mif.dhit} !== 2'b00) begin miscompares++; $display("FAIL rst_hits got %b%b want 00", mif.ihit, mif.dhit); end
    vectors++; if ({mif.iload, mif.dload} !== 64'h0) begin miscompares++; $display("FAIL rst_loads got %h %h want 0", mif.iload, mif.dload); end
    vectors++; if ({mif.ramaddr, mif.ramstore} !== 64'h0) begin miscompares++; $display("FAIL rst_addr_store got %h %h want 0", mif.ramaddr, mif.ramstore); end
    vectors++; if (mif.err_cnt !== 8'h00) begin miscompares++; $display("FAIL rst_err_cnt got %0d want 0", mif.err_cnt); end
    nRST = 1'b1;
    exp_err = 0;
    step();
  endtask

  task automatic test_single_fetch();
    mif.iREN     = 1'b1;
    mif.iaddr    = 32'h40;
    mif.ramstate = BUSY;
    mif.ramload  = 32'h2402000A;
    @(negedge CLK);
    vectors++; if (mif.ramREN !== 1'b0) begin miscompares++; $display("FAIL sf_idle_ren got %b want 0", mif.ramREN); end
    step();
    for (int c = 1; c <= 3; c++) begin
      mif.ramstate = (c == 3) ? ACCESS : BUSY;
      @(negedge CLK);
      vectors++; if (mif.ramREN !== 1'b1 || mif.ramaddr !== 32'h40) begin miscompares++; $display("FAIL sf_ren_addr c%0d got %b %h want 1 00000040", c, mif.ramREN, mif.ramaddr); end
      vectors++; if (mif.ihit !== (c == 3)) begin miscompares++; $display("FAIL sf_ihit c%0d got %b want %b", c, mif.ihit, (c == 3)); end
      if (c == 3) begin
        vectors++; if (mif.iload !== 32'h2402000A) begin miscompares++; $display("FAIL sf_iload got %h want 2402000a", mif.iload); end
      end
      step();
    end
    mif.iREN     = 1'b0;
    mif.ramstate = FREE;
    @(negedge CLK);
    vectors++; if (mif.ihit !== 1'b0 || mif.ramREN !== 1'b0) begin miscompares++; $display("FAIL sf_after got ihit=%b ren=%b want 0 0", mif.ihit, mif.ramREN); end
    step();
  endtask

  task automatic test_collision();
    mif.iREN     = 1'b1;
    mif.iaddr    = 32'h100;
    mif.dWEN     = 1'b1;
    mif.daddr    = 32'h80;
    mif.dstore   = 32'hDEADBEEF;
    mif.ramstate = ACCESS;
    mif.ramload  = 32'h11112222;
    @(negedge CLK);
    vectors++; if ({mif.ramREN, mif.ramWEN} !== 2'b00) begin miscompares++; $display("FAIL col_idle got %b%b want 00", mif.ramREN, mif.ramWEN); end
    step();
    @(negedge CLK);
    vectors++; if ({mif.ramWEN, mif.ramREN} !== 2'b10) begin miscompares++; $display("FAIL col_dserv_strobe got wen=%b ren=%b want 1 0", mif.ramWEN, mif.ramREN); end
    vectors++; if (mif.ramaddr !== 32'h80 || mif.ramstore !== 32'hDEADBEEF) begin miscompares++; $display("FAIL col_dserv_cmd got %h %h want 00000080 deadbeef", mif.ramaddr, mif.ramstore); end
    vectors++; if ({mif.dhit, mif.ihit} !== 2'b10) begin miscompares++; $display("FAIL col_dhit got dhit=%b ihit=%b want 1 0", mif.dhit, mif.ihit); end
    step();
    mif.dWEN = 1'b0;
    @(negedge CLK);
    vectors++; if ({mif.ramREN, mif.ramWEN, mif.ihit, mif.dhit} !== 4'b0000) begin miscompares++; $display("FAIL col_gap got %b%b%b%b want 0000", mif.ramREN, mif.ramWEN, mif.ihit, mif.dhit); end
    step();
    @(negedge CLK);
    vectors++; if (mif.ramREN !== 1'b1 || mif.ramaddr !== 32'h100) begin miscompares++; $display("FAIL col_iserv got %b %h want 1 00000100", mif.ramREN, mif.ramaddr); end
    vectors++; if (mif.ihit !== 1'b1 || mif.iload !== 32'h11112222) begin miscompares++; $display("FAIL col_ihit got %b %h want 1 11112222", mif.ihit, mif.iload); end
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_starvation();
    byte hits[$];
    mif.iREN     = 1'b1;
    mif.iaddr    = 32'h500;
    mif.dREN     = 1'b1;
    mif.daddr    = 32'h600;
    mif.ramstate = ACCESS;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (mif.ihit && mif.dhit) hits.push_back("B");
      else if (mif.dhit)        hits.push_back("D");
      else if (mif.ihit)        hits.push_back("I");
      step();
    end
    clear_inputs();
    step();
    vectors++; if (hits.size() != 20) begin miscompares++; $display("FAIL starve_count got %0d hits want 20", hits.size()); end
    for (int i = 0; i < 15 && i < hits.size(); i++) begin
      byte want;
      want = ((i % (MAXD + 1)) == MAXD) ? "I" : "D";
      vectors++; if (hits[i] != want) begin miscompares++; $display("FAIL starve_seq[%0d] got %c want %c", i, hits[i], want); end
    end
  endtask

  task automatic test_error_retry();
    mif.dREN     = 1'b1;
    mif.daddr    = 32'h200;
    mif.ramload  = 32'hCAFEF00D;
    mif.ramstate = FREE;
    step();
    mif.ramstate = ERROR;
    @(negedge CLK);
    vectors++; if (mif.ramREN !== 1'b1 || mif.dhit !== 1'b0) begin miscompares++; $display("FAIL err_first got ren=%b dhit=%b want 1 0", mif.ramREN, mif.dhit); end
    step();
    exp_err++;
    mif.ramstate = FREE;
    @(negedge CLK);
    vectors++; if (mif.err_cnt !== 8'(exp_err)) begin miscompares++; $display("FAIL err_cnt got %0d want %0d", mif.err_cnt, exp_err); end
    vectors++; if (mif.ramREN !== 1'b0 || mif.dhit !== 1'b0) begin miscompares++; $display("FAIL err_gap got ren=%b dhit=%b want 0 0", mif.ramREN, mif.dhit); end
    step();
    mif.ramstate = ACCESS;
    @(negedge CLK);
    vectors++; if (mif.dhit !== 1'b1 || mif.dload !== 32'hCAFEF00D) begin miscompares++; $display("FAIL err_retry got %b %h want 1 cafef00d", mif.dhit, mif.dload); end
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_addr_stability();
    mif.iREN     = 1'b1;
    mif.iaddr    = 32'h40;
    mif.ramstate = BUSY;
    step();
    for (int c = 1; c <= 3; c++) begin
      if (c == 2) mif.iaddr = 32'h44;
      if (c == 3) begin mif.ramstate = ACCESS; mif.ramload = 32'h8C420000; end
      @(negedge CLK);
      vectors++; if (mif.ramaddr !== 32'h40) begin miscompares++; $display("FAIL stab_addr c%0d got %h want 00000040", c, mif.ramaddr); end
      vectors++; if (mif.ihit !== (c == 3)) begin miscompares++; $display("FAIL stab_ihit c%0d got %b want %b", c, mif.ihit, (c == 3)); end
      step();
    end
    clear_inputs();
    step();
  endtask

  task automatic test_reset_mid_dserv();
    mif.dWEN     = 1'b1;
    mif.daddr    = 32'h300;
    mif.dstore   = 32'h12345678;
    mif.ramstate = BUSY;
    step();
    @(negedge CLK);
    vectors++; if (mif.ramWEN !== 1'b1) begin miscompares++; $display("FAIL rstd_pre got wen=%b want 1", mif.ramWEN); end
    step();
    nRST = 1'b0;
    @(negedge CLK);
    vectors++; if (mif.ramWEN !== 1'b1 || mif.dhit !== 1'b0) begin miscompares++; $display("FAIL rstd_during got wen=%b dhit=%b want 1 0", mif.ramWEN, mif.dhit); end
    step();
    nRST         = 1'b1;
    mif.dWEN     = 1'b0;
    mif.ramstate = ACCESS;
    exp_err      = 0;
    @(negedge CLK);
    vectors++; if ({mif.ramREN, mif.ramWEN, mif.dhit, mif.ihit} !== 4'b0000) begin miscompares++; $display("FAIL rstd_after got %b%b%b%b want 0000", mif.ramREN, mif.ramWEN, mif.dhit, mif.ihit); end
    vectors++; if (mif.err_cnt !== 8'(exp_err)) begin miscompares++; $display("FAIL rstd_err_cnt got %0d want %0d", mif.err_cnt, exp_err); end
    vectors++; if ({mif.ramaddr, mif.ramstore} !== 64'h0) begin miscompares++; $display("FAIL rstd_cmd got %h %h want 0", mif.ramaddr, mif.ramstore); end
    step();
    clear_inputs();
    step();
  endtask

  // Reference model: who owns the RAM (0 none, 1 fetch, 2 data), the command
  // captured at grant, the running data streak and the error tally.
  task automatic test_random();
    int    m_owner, m_streak, m_err, r;
    word_t m_addr, m_store;
    bit    m_wr, acc, err, exp_ren, exp_wen, exp_ihit, exp_dhit, dq;

    nRST = 1'b0;
    clear_inputs();
    step();
    nRST = 1'b1;
    m_owner = 0; m_streak = 0; m_err = 0; m_addr = '0; m_store = '0; m_wr = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      mif.iREN    = ($urandom_range(0, 3) != 0);
      mif.dREN    = ($urandom_range(0, 2) == 0);
      mif.dWEN    = ($urandom_range(0, 3) == 0);
      mif.iaddr   = $urandom;
      mif.daddr   = $urandom;
      mif.dstore  = $urandom;
      mif.ramload = $urandom;
      r = $urandom_range(0, 99);
      mif.ramstate = (r < 40) ? ACCESS : (r < 65) ? BUSY : (r < 78) ? FREE : ERROR;
      nRST = ($urandom_range(0, 199) != 0);

      @(negedge CLK);
      acc      = (mif.ramstate == ACCESS);
      err      = (mif.ramstate == ERROR);
      dq       = mif.dREN | mif.dWEN;
      exp_ren  = (m_owner == 1) || (m_owner == 2 && !m_wr);
      exp_wen  = (m_owner == 2) && m_wr;
      exp_ihit = (m_owner == 1) && acc && mif.iREN;
      exp_dhit = (m_owner == 2) && acc && dq;

      vectors++; if (mif.ramREN !== exp_ren) begin miscompares++; $display("FAIL rnd_ramREN n%0d got %b want %b", n, mif.ramREN, exp_ren); end
      vectors++; if (mif.ramWEN !== exp_wen) begin miscompares++; $display("FAIL rnd_ramWEN n%0d got %b want %b", n, mif.ramWEN, exp_wen); end
      vectors++; if (mif.ramaddr !== m_addr) begin miscompares++; $display("FAIL rnd_ramaddr n%0d got %h want %h", n, mif.ramaddr, m_addr); end
      vectors++; if (mif.ihit !== exp_ihit) begin miscompares++; $display("FAIL rnd_ihit n%0d got %b want %b", n, mif.ihit, exp_ihit); end
      vectors++; if (mif.dhit !== exp_dhit) begin miscompares++; $display("FAIL rnd_dhit n%0d got %b want %b", n, mif.dhit, exp_dhit); end
      vectors++; if (mif.err_cnt !== 8'(m_err)) begin miscompares++; $display("FAIL rnd_err_cnt n%0d got %0d want %0d", n, mif.err_cnt, m_err); end
      if (m_owner == 2) begin
        vectors++; if (mif.ramstore !== m_store) begin miscompares++; $display("FAIL rnd_ramstore n%0d got %h want %h", n, mif.ramstore, m_store); end
      end
      if (exp_ihit) begin
        vectors++; if (mif.iload !== mif.ramload) begin miscompares++; $display("FAIL rnd_iload n%0d got %h want %h", n, mif.iload, mif.ramload); end
      end
      if (exp_dhit) begin
        vectors++; if (mif.dload !== mif.ramload) begin miscompares++; $display("FAIL rnd_dload n%0d got %h want %h", n, mif.dload, mif.ramload); end
      end

      if (!nRST) begin
        m_owner = 0; m_streak = 0; m_err = 0; m_addr = '0; m_store = '0; m_wr = 1'b0;
      end else begin
        int nxt_owner;
        nxt_owner = m_owner;
        if (m_owner == 0) begin
          if (dq && !(mif.iREN && m_streak == MAXD)) begin
            nxt_owner = 2; m_addr = mif.daddr; m_wr = mif.dWEN; m_store = mif.dstore;
          end else if (mif.iREN) begin
            nxt_owner = 1; m_addr = mif.iaddr; m_wr = mif.dWEN; m_store = mif.dstore;
          end
        end else if (acc || err) begin
          nxt_owner = 0;
        end
        if (m_owner != 0 && err && m_err < 255) m_err++;
        if (!mif.iREN)                 m_streak = 0;
        else if (m_owner == 1 && acc)  m_streak = 0;
        else if (m_owner == 2 && acc)  m_streak = (m_streak + 1 > MAXD) ? MAXD : m_streak + 1;
        m_owner = nxt_owner;
      end
      step();
    end
    nRST = 1'b1;
    clear_inputs();
    step();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_err     = 0;
    nRST        = 1'b0;
    clear_inputs();
    step();
    test_reset();
    test_single_fetch();
    test_collision();
    test_starvation();
    test_error_retry();
    test_addr_stability();
    test_reset_mid_dserv();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
